ddc_mixer: RTL and testbench

Receive-side digital down-converter: mixes a real 16-bit passband sample stream with a loaded cos/sin carrier table to produce baseband I/Q. It is the counterpart of the transmit `duc`. It sits between the ADC capture stream and the demodulator, with AXI-Stream handshakes and an output FIFO on both sides. Phase restarts at every frame boundary (`tlast`), so frames align with the `duc` carrier period.

---
 rtl/ddc_mixer.sv | 207 ++++++++++++++++++++
 tb/tb_ddc_mixer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_mixer.sv
// ddc_mixer: receive-side digital down-converter.
// Mixes a real 16-bit passband stream with a loadable cos/sin carrier table
// and produces baseband I/Q through a 3-stage pipeline into a FWFT output FIFO.
// The carrier phase restarts after every tlast so frames line up with the duc.
// Optional feature: define DDC_ROUND_EN to round half up (+64) before the >>> 7
// scaling; by default the scaled products are truncated.

module ddc_mixer #(
  parameter int PERIOD     = 680,
  parameter int LUT_AW     = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic [15:0]       s_axis_data_tdata,
  input  logic              s_axis_data_tlast,
  input  logic              lut_wr_en,
  input  logic [LUT_AW-1:0] lut_wr_addr,
  input  logic [7:0]        lut_wr_cos,
  input  logic [7:0]        lut_wr_sin,
  output logic              m_axis_data_tvalid_ddc_I,
  output logic              m_axis_data_tvalid_ddc_Q,
  input  logic              m_axis_data_tready_ddc_I,
  input  logic              m_axis_data_tready_ddc_Q,
  output logic [15:0]       m_axis_data_tdata_ddc_I,
  output logic [15:0]       m_axis_data_tdata_ddc_Q,
  output logic              m_axis_data_tlast_ddc_I,
  output logic              m_axis_data_tlast_ddc_Q
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [LUT_AW-1:0] PH_LAST   = LUT_AW'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  // Carrier tables; deliberately not reset so a reload is not needed after reset.
  logic signed [7:0] cos_mem [2**LUT_AW];
  logic signed [7:0] sin_mem [2**LUT_AW];

  logic [LUT_AW-1:0] ph;

  logic              s1_valid;
  logic              s1_last;
  logic signed [15:0] s1_x;
  logic signed [7:0]  s1_cos;
  logic signed [7:0]  s1_sin;

  logic              s2_valid;
  logic              s2_last;
  logic signed [23:0] s2_pi;
  logic signed [23:0] s2_pq;

  logic              s3_valid;
  logic              s3_last;
  logic signed [15:0] s3_i;
  logic signed [15:0] s3_q;

  logic [32:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;
  logic [32:0]        head;

  logic accept;
  logic push;
  logic pop;
  logic out_valid;
  logic fifo_full;

  // Scale a 24-bit product by 2^-7 (optionally rounded) and clamp to 16 bits.
  function automatic logic signed [15:0] scale_sat(input logic signed [23:0] p);
    logic signed [24:0] t;
    logic signed [17:0] s;
    t = {p[23], p};
`ifdef DDC_ROUND_EN
    t = t + 25'sd64;
`endif
    s = 18'(t >>> 7);
    if (s > 18'sd32767) begin
      return 16'sh7fff;
    end else if (s < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return s[15:0];
    end
  endfunction

  // Samples already committed (pipeline plus FIFO) must never exceed the FIFO size.
  assign occupancy = {1'b0, fifo_count}
                   + {{CNT_W{1'b0}}, s1_valid}
                   + {{CNT_W{1'b0}}, s2_valid}
                   + {{CNT_W{1'b0}}, s3_valid};

  assign s_axis_data_tready = !reset && (occupancy < OCC_LIMIT);
  assign accept    = s_axis_data_tvalid && s_axis_data_tready;
  assign push      = s3_valid;
  assign fifo_full = (fifo_count == CNT_FULL);
  assign out_valid = !reset && (fifo_count != '0);
  assign pop       = out_valid && m_axis_data_tready_ddc_I && m_axis_data_tready_ddc_Q;
  assign head      = fifo_mem[rd_ptr];

  assign m_axis_data_tvalid_ddc_I = out_valid;
  assign m_axis_data_tvalid_ddc_Q = out_valid;
  assign m_axis_data_tdata_ddc_I  = out_valid ? head[32:17] : 16'd0;
  assign m_axis_data_tdata_ddc_Q  = out_valid ? head[16:1]  : 16'd0;
  assign m_axis_data_tlast_ddc_I  = out_valid && head[0];
  assign m_axis_data_tlast_ddc_Q  = out_valid && head[0];

  // Table writes; a same-cycle read of the written address sees the old entry.
  always_ff @(posedge aclk) begin
    if (lut_wr_en) begin
      cos_mem[lut_wr_addr] <= lut_wr_cos;
      sin_mem[lut_wr_addr] <= lut_wr_sin;
    end
  end

  // Stage 1: capture the accepted sample, look up the carrier, advance the phase.
  always_ff @(posedge aclk) begin
    if (reset) begin
      ph       <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_cos   <= '0;
      s1_sin   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x    <= s_axis_data_tdata;
        s1_last <= s_axis_data_tlast;
        s1_cos  <= cos_mem[ph];
        s1_sin  <= sin_mem[ph];
        if (s_axis_data_tlast || (ph == PH_LAST)) begin
          ph <= '0;
        end else begin
          ph <= ph + 1'b1;
        end
      end
    end
  end

  // Stage 2: full-precision mix; Q takes the negated sine product.
  always_ff @(posedge aclk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_pi    <= '0;
      s2_pq    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_pi    <= 24'(s1_x) * 24'(s1_cos);
      s2_pq    <= -(24'(s1_x) * 24'(s1_sin));
    end
  end

  // Stage 3: scale and saturate, ready to be pushed into the FIFO.
  always_ff @(posedge aclk) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_i     <= '0;
      s3_q     <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_i     <= scale_sat(s2_pi);
      s3_q     <= scale_sat(s2_pq);
    end
  end

  // FIFO storage keeps I, Q and last in one word so the channels cannot separate.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s3_i, s3_q, s3_last};
    end
  end

  // FIFO pointers and fill level; push and pop together leave the count unchanged.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Backpressure accounting guarantees no write ever lands on a full FIFO.
  fifo_no_overflow: assert property (@(posedge aclk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_ddc_mixer.sv
// tb_ddc_mixer: self-checking bench for ddc_mixer.
// A behavioural model (integer arithmetic over a shadow carrier table and a
// phase counter) predicts every output word; a queue orders expectations.

module tb_ddc_mixer;

  localparam int PERIOD     = 680;
  localparam int LUT_AW     = 10;
  localparam int FIFO_DEPTH = 16;

  logic              aclk = 1'b0;
  logic              reset;
  logic              s_axis_data_tvalid;
  logic              s_axis_data_tready;
  logic [15:0]       s_axis_data_tdata;
  logic              s_axis_data_tlast;
  logic              lut_wr_en;
  logic [LUT_AW-1:0] lut_wr_addr;
  logic [7:0]        lut_wr_cos;
  logic [7:0]        lut_wr_sin;
  logic              m_axis_data_tvalid_ddc_I;
  logic              m_axis_data_tvalid_ddc_Q;
  logic              m_axis_data_tready_ddc_I;
  logic              m_axis_data_tready_ddc_Q;
  logic [15:0]       m_axis_data_tdata_ddc_I;
  logic [15:0]       m_axis_data_tdata_ddc_Q;
  logic              m_axis_data_tlast_ddc_I;
  logic              m_axis_data_tlast_ddc_Q;

  always #5 aclk = ~aclk;

  ddc_mixer #(
    .PERIOD(PERIOD),
    .LUT_AW(LUT_AW),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tready(s_axis_data_tready),
    .s_axis_data_tdata(s_axis_data_tdata),
    .s_axis_data_tlast(s_axis_data_tlast),
    .lut_wr_en(lut_wr_en),
    .lut_wr_addr(lut_wr_addr),
    .lut_wr_cos(lut_wr_cos),
    .lut_wr_sin(lut_wr_sin),
    .m_axis_data_tvalid_ddc_I(m_axis_data_tvalid_ddc_I),
    .m_axis_data_tvalid_ddc_Q(m_axis_data_tvalid_ddc_Q),
    .m_axis_data_tready_ddc_I(m_axis_data_tready_ddc_I),
    .m_axis_data_tready_ddc_Q(m_axis_data_tready_ddc_Q),
    .m_axis_data_tdata_ddc_I(m_axis_data_tdata_ddc_I),
    .m_axis_data_tdata_ddc_Q(m_axis_data_tdata_ddc_Q),
    .m_axis_data_tlast_ddc_I(m_axis_data_tlast_ddc_I),
    .m_axis_data_tlast_ddc_Q(m_axis_data_tlast_ddc_Q)
  );

  typedef struct {
    int i;
    int q;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   cos_tab [PERIOD];
  int   sin_tab [PERIOD];
  int   model_ph;

  int total;
  int bad;
  int tick_n;
  int accepts;
  int pops;
  int first_acc_tick;
  int first_pop_tick;
  int last_pop_tick;

  // Every comparison funnels through here so the counters stay consistent.
  task automatic check_output(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Divide by 128 rounding toward minus infinity, optional +64, clamp to int16.
  function automatic int model_scale(input longint p);
    longint t;
`ifdef DDC_ROUND_EN
    t = p + 64;
`else
    t = p;
`endif
    if (t >= 0) t = t / 128;
    else        t = -((-t + 127) / 128);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  // Predict one accepted sample and move the model phase on.
  task automatic model_accept(input int x, input bit last);
    exp_t e;
    e.i    = model_scale(longint'(x) * cos_tab[model_ph]);
    e.q    = model_scale(-(longint'(x) * sin_tab[model_ph]));
    e.last = last;
    exp_q.push_back(e);
    model_ph = last ? 0 : (model_ph + 1) % PERIOD;
  endtask

  // One clock cycle: sample handshakes mid-cycle, update model, cross the edge.
  task automatic tick();
    exp_t e;
    bit acc;
    bit pop;
    #1;
    acc = (s_axis_data_tvalid === 1'b1) && (s_axis_data_tready === 1'b1);
    pop = (m_axis_data_tvalid_ddc_I === 1'b1) && (m_axis_data_tready_ddc_I === 1'b1) &&
          (m_axis_data_tready_ddc_Q === 1'b1);
    if (pop) begin
      if (exp_q.size() == 0) begin
        check_output("pop_without_sample", 1, int'(exp_q.size()));
      end else begin
        e = exp_q.pop_front();
        check_output("data_I", int'($signed(m_axis_data_tdata_ddc_I)), e.i);
        check_output("data_Q", int'($signed(m_axis_data_tdata_ddc_Q)), e.q);
        check_output("last_I", int'(m_axis_data_tlast_ddc_I), int'(e.last));
        check_output("last_Q", int'(m_axis_data_tlast_ddc_Q), int'(e.last));
        check_output("valid_Q", int'(m_axis_data_tvalid_ddc_Q), 1);
        pops++;
        if (first_pop_tick < 0) first_pop_tick = tick_n;
        last_pop_tick = tick_n;
      end
    end
    if (acc) begin
      model_accept(int'($signed(s_axis_data_tdata)), s_axis_data_tlast);
      accepts++;
      if (first_acc_tick < 0) first_acc_tick = tick_n;
    end
    if ((lut_wr_en === 1'b1) && (int'(lut_wr_addr) < PERIOD)) begin
      cos_tab[lut_wr_addr] = int'($signed(lut_wr_cos));
      sin_tab[lut_wr_addr] = int'($signed(lut_wr_sin));
    end
    if (reset === 1'b1) begin
      exp_q.delete();
      model_ph = 0;
    end
    @(posedge aclk);
    tick_n++;
    @(negedge aclk);
  endtask

  // Drive the stream and output readies for one cycle.
  task automatic apply_stimulus(input bit v, input int x, input bit last, input bit ri, input bit rq);
    s_axis_data_tvalid       = v;
    s_axis_data_tdata        = 16'(x);
    s_axis_data_tlast        = last;
    m_axis_data_tready_ddc_I = ri;
    m_axis_data_tready_ddc_Q = rq;
    tick();
  endtask

  // Write one carrier entry while the stream idles.
  task automatic load_entry(input int addr, input int c, input int s);
    lut_wr_en   = 1'b1;
    lut_wr_addr = LUT_AW'(addr);
    lut_wr_cos  = 8'(c);
    lut_wr_sin  = 8'(s);
    apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    lut_wr_en   = 1'b0;
  endtask

  // Offer one sample with random valid/ready gaps until it is taken.
  task automatic send(input int x, input bit last);
    int a0;
    int guard;
    a0 = accepts;
    guard = 0;
    while ((accepts == a0) && (guard < 100)) begin
      apply_stimulus($urandom_range(0, 3) != 0, x, last,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      guard++;
    end
    if (accepts == a0) check_output("send_timeout", accepts - a0, 1);
  endtask

  // Empty the pipeline and FIFO, then idle briefly to catch stray outputs.
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0) && (guard < 200)) begin
      apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
      guard++;
    end
    check_output("drain_empty", int'(exp_q.size()), 0);
    apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  // Bound the whole run in case the design stalls forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios, each checked against the model.
  initial begin
    int a0;
    int p0;
    total = 0; bad = 0; tick_n = 0; accepts = 0; pops = 0;
    first_acc_tick = -1; first_pop_tick = -1; last_pop_tick = -1;
    model_ph = 0;
    reset = 1'b1;
    s_axis_data_tvalid = 1'b0; s_axis_data_tdata = '0; s_axis_data_tlast = 1'b0;
    lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_cos = '0; lut_wr_sin = '0;
    m_axis_data_tready_ddc_I = 1'b0; m_axis_data_tready_ddc_Q = 1'b0;
    $display("[TB] start");

    // Reset state
    @(negedge aclk);
    tick();
    tick();
    #1;
    check_output("reset_tready",  int'(s_axis_data_tready), 0);
    check_output("reset_valid_I", int'(m_axis_data_tvalid_ddc_I), 0);
    check_output("reset_valid_Q", int'(m_axis_data_tvalid_ddc_Q), 0);
    check_output("reset_data_I",  int'(m_axis_data_tdata_ddc_I), 0);
    check_output("reset_data_Q",  int'(m_axis_data_tdata_ddc_Q), 0);
    check_output("reset_last_I",  int'(m_axis_data_tlast_ddc_I), 0);
    check_output("reset_last_Q",  int'(m_axis_data_tlast_ddc_Q), 0);
    tick();
    reset = 1'b0;
    #1;
    check_output("tready_after_reset", int'(s_axis_data_tready), 1);

    // Identity mix
    for (int k = 0; k < PERIOD; k++) load_entry(k, 64, 0);
    apply_stimulus(1'b1, 1000, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1001, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1002, 1'b1, 1'b1, 1'b1);
    drain();

    // Saturation corners and random single-sample frames at phase 0
    load_entry(0, -128, -128);
    apply_stimulus(1'b1, -32768, 1'b1, 1'b1, 1'b1);
    drain();
    load_entry(0, 127, 127);
    apply_stimulus(1'b1, 32767, 1'b1, 1'b1, 1'b1);
    load_entry(0, -128, 127);
    apply_stimulus(1'b1, 32767, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, -32768, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      load_entry(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      apply_stimulus(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b1, 1'b1, 1'b1);
    end
    drain();

    // Phase wrap at PERIOD and restart after tlast; I equals the phase mod 128
    for (int k = 0; k < PERIOD; k++) load_entry(k, k % 128, int'($urandom_range(0, 255)) - 128);
    for (int n = 0; n < 700; n++) send(128, 1'b0);
    for (int n = 0; n < 12; n++) send(128, n == 5);
    drain();

    // Backpressure: both readies low, then only one ready high at a time
    a0 = accepts;
    for (int n = 0; n < 30; n++)
      apply_stimulus(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0, 1'b0);
    check_output("bp_accepted", accepts - a0, FIFO_DEPTH);
    check_output("bp_tready_low", int'(s_axis_data_tready), 0);
    for (int n = 0; n < 5; n++) apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check_output("bp_q_low_tready", int'(s_axis_data_tready), 0);
    check_output("bp_q_low_valid", int'(m_axis_data_tvalid_ddc_I), 1);
    check_output("bp_q_low_head", int'($signed(m_axis_data_tdata_ddc_I)), exp_q[0].i);
    for (int n = 0; n < 5; n++) apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_output("bp_i_low_tready", int'(s_axis_data_tready), 0);
    check_output("bp_i_low_head", int'($signed(m_axis_data_tdata_ddc_Q)), exp_q[0].q);
    drain();

    // Latency and throughput with in-stream writes to the address being read
    first_acc_tick = -1;
    first_pop_tick = -1;
    a0 = accepts;
    p0 = pops;
    for (int n = 0; n < 1000; n++) begin
      if ((n % 8) == 3) begin
        lut_wr_en   = 1'b1;
        lut_wr_addr = LUT_AW'(model_ph);
        lut_wr_cos  = 8'($urandom);
        lut_wr_sin  = 8'($urandom);
      end
      apply_stimulus(1'b1, int'($urandom_range(0, 65535)) - 32768,
                     $urandom_range(0, 49) == 0, 1'b1, 1'b1);
      lut_wr_en = 1'b0;
    end
    drain();
    check_output("tp_accepts", accepts - a0, 1000);
    check_output("tp_pops", pops - p0, 1000);
    check_output("tp_latency", first_pop_tick - first_acc_tick - 1, 3);
    check_output("tp_no_bubbles", last_pop_tick - first_pop_tick, 999);

    // Reset mid-frame with samples buffered
    for (int n = 0; n < 10; n++)
      apply_stimulus(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_output("pre_reset_valid", int'(m_axis_data_tvalid_ddc_I), 1);
    reset = 1'b1;
    s_axis_data_tvalid = 1'b1;
    #1;
    check_output("mid_reset_valid", int'(m_axis_data_tvalid_ddc_I), 0);
    check_output("mid_reset_data", int'(m_axis_data_tdata_ddc_I), 0);
    check_output("mid_reset_tready", int'(s_axis_data_tready), 0);
    tick();
    reset = 1'b0;
    s_axis_data_tvalid = 1'b0;
    #1;
    check_output("post_reset_valid_I", int'(m_axis_data_tvalid_ddc_I), 0);
    check_output("post_reset_valid_Q", int'(m_axis_data_tvalid_ddc_Q), 0);
    check_output("post_reset_tready", int'(s_axis_data_tready), 1);
    for (int n = 0; n < 8; n++)
      apply_stimulus(1'b1, int'($urandom_range(0, 65535)) - 32768, n == 7, 1'b1, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
